// File: rtl/mc_controller.sv
// Multi-cycle FSM controller for the MIPS datapath.
// Drives all datapath enables and mux selects from its state and the IR fields.
module mc_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [2:0] NPCOp,
  output logic [2:0] ALUOp,
  output logic [1:0] EXTOp,
  output logic       ALUSrc,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       mem_err
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXE    = 4'd2,
    ALUWB  = 4'd3,
    MA     = 4'd4,
    MR     = 4'd5,
    MWB    = 4'd6,
    MW     = 4'd7,
    BR     = 4'd8,
    JUMP   = 4'd9
  } state_t;

  state_t cur, nxt;
  logic [CW-1:0] cnt;

  logic is_r, addu, subu, jr, ori, lui;
  logic lw, sw, beq, j, jal;
  logic alu_cls, mem_cls, jmp_cls;
  logic in_mem, timeout;

  assign is_r = (op == 6'h00);
  assign addu = is_r && (func == 6'h21);
  assign subu = is_r && (func == 6'h23);
  assign jr   = is_r && (func == 6'h08);
  assign ori  = (op == 6'h0d);
  assign lui  = (op == 6'h0f);
  assign lw   = (op == 6'h23);
  assign sw   = (op == 6'h2b);
  assign beq  = (op == 6'h04);
  assign j    = (op == 6'h02);
  assign jal  = (op == 6'h03);

  assign alu_cls = addu | subu | ori | lui;
  assign mem_cls = lw | sw;
  assign jmp_cls = j | jal | jr;

  assign in_mem  = (cur == MR) || (cur == MW);
  assign timeout = in_mem && !mem_ready && (cnt == LAST);

  assign state = cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur     <= FETCH;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      cur <= nxt;
      if (timeout) begin
        cnt     <= '0;
        mem_err <= 1'b1;
      end else if (in_mem && !mem_ready) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  always_comb begin
    nxt        = cur;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    NPCOp      = 3'b000;
    ALUOp      = 3'b000;
    EXTOp      = 2'b00;
    ALUSrc     = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    instr_done = 1'b0;
    unique case (cur)
      FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        nxt     = DECODE;
      end
      DECODE: begin
        unique case (1'b1)
          alu_cls: nxt = EXE;
          mem_cls: nxt = MA;
          beq:     nxt = BR;
          jmp_cls: nxt = JUMP;
          default: begin
            nxt        = FETCH;
            instr_done = 1'b1;
          end
        endcase
      end
      EXE: begin
        nxt = ALUWB;
        unique case (1'b1)
          subu: ALUOp = 3'b001;
          ori: begin
            ALUOp  = 3'b010;
            ALUSrc = 1'b1;
          end
          lui: begin
            EXTOp  = 2'b10;
            ALUSrc = 1'b1;
          end
          default: ALUOp = 3'b000;
        endcase
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = is_r ? 2'b01 : 2'b00;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      MA, MR, MW: begin
        ALUSrc = 1'b1;
        EXTOp  = 2'b01;
        if (cur == MA) begin
          nxt = lw ? MR : MW;
        end else if (cur == MR) begin
          MemRead = 1'b1;
          if (mem_ready) nxt = MWB;
          else if (timeout) nxt = FETCH;
        end else begin
          MemWrite = 1'b1;
          if (mem_ready) begin
            nxt        = FETCH;
            instr_done = 1'b1;
          end else if (timeout) begin
            nxt = FETCH;
          end
        end
      end
      MWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      BR: begin
        ALUOp      = 3'b001;
        EXTOp      = 2'b01;
        NPCOp      = 3'b001;
        PCWrite    = zero;
        instr_done = 1'b1;
        nxt        = FETCH;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        NPCOp      = jr ? 3'b011 : 3'b010;
        instr_done = 1'b1;
        nxt        = FETCH;
        if (jal) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
      end
      default: nxt = FETCH;
    endcase
    // Enables are held off for the whole reset cycle, whatever the state.
    if (!reset) begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule
